// File: rtl/mips_enc_pkg.sv
// Shared types and field constants for the MIPS instruction encoder.
// Optional ORI support is selected by the MIPS_ENC_ORI_EN macro.
package mips_enc_pkg;

  typedef enum logic [2:0] {
    K_RTYPE = 3'd0,
    K_LW    = 3'd1,
    K_SW    = 3'd2,
    K_BEQ   = 3'd3,
    K_ADDI  = 3'd4,
    K_J     = 3'd5,
    K_ORI   = 3'd6,
    K_RSVD7 = 3'd7
  } instr_kind_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] SLT = 6'b101010;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALT   = 2'd1,
    SEALED = 2'd2
  } enc_state_t;

  // Jump-to-self used to terminate a sealed program.
  function automatic logic [31:0] halt_word(input logic [25:0] target);
    return {OP_J, target};
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: symbolic kind + fields -> 32-bit MIPS word.
// Kind 6 encodes ORI only when MIPS_ENC_ORI_EN is defined.
module mips_instr_pack
  import mips_enc_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [5:0]  funct_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_c_o,
  output logic        illegal_c_o
);

  always_comb begin
    word_c_o    = '0;
    illegal_c_o = 1'b0;
    case (instr_kind_t'(kind_i))
      K_RTYPE: word_c_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, funct_i};
      K_LW:    word_c_o = {OP_LW,   rs_i, rt_i, imm_i};
      K_SW:    word_c_o = {OP_SW,   rs_i, rt_i, imm_i};
      K_BEQ:   word_c_o = {OP_BEQ,  rs_i, rt_i, imm_i};
      K_ADDI:  word_c_o = {OP_ADDI, rs_i, rt_i, imm_i};
      K_J:     word_c_o = {OP_J, target_i};
`ifdef MIPS_ENC_ORI_EN
      K_ORI:   word_c_o = {OP_ORI,  rs_i, rt_i, imm_i};
`endif
      default: illegal_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Sequential imem writer: accepts encode requests, writes words in order, can seal with a self-jump.
// Build with MIPS_ENC_ORI_EN to accept kind 6 as ORI.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          clr_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [2:0]    in_kind_i,
  input  logic [5:0]    in_funct_i,
  input  logic [4:0]    in_rs_i,
  input  logic [4:0]    in_rt_i,
  input  logic [4:0]    in_rd_i,
  input  logic [15:0]   in_imm_i,
  input  logic [25:0]   in_target_i,
  input  logic          seal_i,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic [31:0]   wdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          sealed_o,
  output logic          err_o,
  output logic          trunc_o
);

  enc_state_t    state_q, state_d;
  logic          pend_q, pend_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          trunc_q, trunc_d;

  logic [31:0] word_c;
  logic        illegal_c;
  logic        full_c;
  logic        accept_c;

  mips_instr_pack u_pack (
    .kind_i     (in_kind_i),
    .funct_i    (in_funct_i),
    .rs_i       (in_rs_i),
    .rt_i       (in_rt_i),
    .rd_i       (in_rd_i),
    .imm_i      (in_imm_i),
    .target_i   (in_target_i),
    .word_c_o   (word_c),
    .illegal_c_o(illegal_c)
  );

  assign full_c     = (count_q == (AW+1)'(DEPTH));
  assign in_ready_o = (state_q == RUN) && !full_c && !pend_q;
  assign accept_c   = in_valid_i && in_ready_o;

  // Next-state: request writes, deferred seal, halt emission, clr restart.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    trunc_d = trunc_q;
    if (clr_i) begin
      state_d = RUN;
      pend_d  = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
      count_d = '0;
      err_d   = 1'b0;
      trunc_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept_c) begin
            if (illegal_c) begin
              err_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              waddr_d = count_q[AW-1:0];
              wdata_d = word_c;
              count_d = count_q + (AW+1)'(1);
            end
            pend_d = seal_i;
          end else if (pend_q || seal_i) begin
            pend_d = 1'b0;
            if (full_c) begin
              state_d = SEALED;
              trunc_d = 1'b1;
            end else begin
              state_d = HALT;
              we_d    = 1'b1;
              waddr_d = count_q[AW-1:0];
              wdata_d = halt_word(26'(count_q));
              count_d = count_q + (AW+1)'(1);
            end
          end
        end
        HALT:    state_d = SEALED;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
      trunc_q <= trunc_d;
    end
  end

  assign we_o     = we_q;
  assign waddr_o  = waddr_q;
  assign wdata_o  = wdata_q;
  assign count_o  = count_q;
  assign full_o   = full_c;
  assign sealed_o = (state_q == SEALED);
  assign err_o    = err_q;
  assign trunc_o  = trunc_q;

endmodule
